// File: rtl/dac_transmit.sv
// Serial transmitter for one 12-bit sample to a DAC121S101-class DAC using a 16-bit SPI frame.
// A rising edge on the synchronised sampling clock cs starts a frame, and the frame is sent MSB first.
module dac_transmit #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        cs,
    input  logic [11:0] sample,
    input  logic [1:0]  mode,
    output logic        sync_n,
    output logic        sclk,
    output logic        mosi,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam int unsigned    DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StShift = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;

    logic            s1_q, s2_q, s3_q;
    logic            rise, tick;
    logic [15:0]     frame;
    logic [1:0]      state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [15:0]     shift_q, shift_d;
    logic            sync_n_q, sync_n_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            overrun_q, overrun_d;

    assign rise  = s2_q & ~s3_q;
    assign tick  = (div_q == DivMax);
    assign frame = {2'b00, mode, sample};

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        sync_n_d  = sync_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        // A rise in the cycle where done is high also counts as an overrun.
        overrun_d = rise & ((state_q != StIdle) | done_q);

        case (state_q)
            StIdle: begin
                div_d    = '0;
                sync_n_d = 1'b1;
                sclk_d   = 1'b1;
                if (rise && !done_q) begin
                    shift_d  = {frame[14:0], 1'b0};
                    mosi_d   = frame[15];
                    sync_n_d = 1'b0;
                    bitcnt_d = 4'd0;
                    busy_d   = 1'b1;
                    state_d  = StShift;
                end
            end
            StShift: begin
                div_d = tick ? '0 : div_q + DivW'(1);
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                    end else begin
                        sclk_d = 1'b1;
                        if (bitcnt_q == 4'd15) begin
                            sync_n_d = 1'b1;
                            state_d  = StHold;
                        end else begin
                            bitcnt_d = bitcnt_q + 4'd1;
                            mosi_d   = shift_q[15];
                            shift_d  = {shift_q[14:0], 1'b0};
                        end
                    end
                end
            end
            StHold: begin
                div_d = tick ? '0 : div_q + DivW'(1);
                if (tick) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    mosi_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d  = StIdle;
                div_d    = '0;
                sync_n_d = 1'b1;
                sclk_d   = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            state_q   <= StIdle;
            div_q     <= '0;
            bitcnt_q  <= 4'd0;
            shift_q   <= 16'd0;
            sync_n_q  <= 1'b1;
            sclk_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            s1_q      <= cs;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            state_q   <= state_d;
            div_q     <= div_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            sync_n_q  <= sync_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign sync_n  = sync_n_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule

// File: doc/dac_transmit.md
Name: dac_transmit

Overview:
- Serial transmitter for a 12-bit audio sample to an SPI-style DAC (DAC121S101-class, 16-bit frame).
- It is the output-side counterpart of the mic capture path: a rising edge on the sampling clock `cs` (20 kHz in the top level) launches one frame carrying `sample`.
- It sits between the audio processing logic and a Pmod connector. It drives `sync_n`, `sclk` and `mosi`, and reports `busy`, `done` and `overrun`.

Parameters:
- CLK_DIV, default 4: number of CLK cycles per sclk half-period. Legal range 1..255. sclk = CLK / (2*CLK_DIV), so the default gives 12.5 MHz from 100 MHz.

Ports:
- CLK  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset. 0 = reset asserted.
- cs  input  1  sampling clock. Asynchronous to CLK in origin and synchronised internally. Its rising edge requests a frame.
- sample  input  12  unsigned sample. Captured on the frame-start cycle.
- mode  input  2  DAC power-down bits, placed in frame[13:12]. 00 = normal operation.
- sync_n  output  1  DAC frame select, active-low.
- sclk  output  1  DAC serial clock. Idles high.
- mosi  output  1  serial data, MSB first.
- busy  output  1  high from frame start until `done`.
- done  output  1  one-CLK pulse when a frame completes.
- overrun  output  1  one-CLK pulse when a cs edge arrives while busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - sync_n=1, sclk=1, mosi=0, busy=0, done=0, overrun=0.
  - State=IDLE; divider, bit counter and synchroniser flops cleared.
  - Asserting reset mid-frame aborts the frame immediately. sync_n returns high with no further sclk edges.
- cs synchroniser and edge detect:
  - cs passes through two flops (s1, s2), plus a third flop s3 for edge detection.
  - rise = s2 & ~s3.
  - sync_n falls on the CLK edge on which `rise` is registered: the 3rd CLK rising edge after cs is first sampled high.
- Frame format: frame = {2'b00, mode, sample}, 16 bits, transmitted MSB first.
- Divider:
  - Counter runs 0..CLK_DIV-1 and produces a one-cycle `tick` when it reaches CLK_DIV-1.
  - It is held at 0 in IDLE and restarts from 0 on frame start.
- State IDLE:
  - Outputs: sync_n=1, sclk=1, busy=0.
  - On rise: latch the frame into a 16-bit shift register, set mosi=frame[15] and sync_n=0, bitcnt=0, busy=1, go to SHIFT.
  - sample and mode are not sampled at any other time.
- State SHIFT, on each tick, sclk toggles:
  - 1→0 (falling edge, where the DAC samples): no data change. This gives mosi CLK_DIV cycles of setup.
  - 0→1 (rising edge):
    - If bitcnt==15: sync_n=1, go to HOLD.
    - Otherwise: bitcnt+1 and mosi = next bit.
  - A frame has exactly 16 sclk falling edges, and sync_n is low for exactly 32*CLK_DIV CLK cycles.
- State HOLD:
  - sclk=1, sync_n=1.
  - On the next tick: done=1 for one cycle, busy=0, mosi=0, go to IDLE.
  - Frame period is 33*CLK_DIV cycles from sync_n falling to done, which is 132 cycles at the default and far below the 5000-cycle period of 20 kHz.
- Overrun:
  - A rise while state≠IDLE is ignored and the frame in flight is unaffected. overrun pulses for one cycle.
  - A rise in the same cycle as done counts as overrun. No frame starts.
- Ordering: sclk and sync_n are registered outputs, with no combinational path from inputs. mosi changes only while sclk is rising or while sync_n is high.

Test Plan:
- Reset values: hold reset=0, toggle cs and sample → sync_n=1, sclk=1, mosi=0, busy=0, done=0, overrun=0 throughout.
- Basic frame: CLK_DIV=4, sample=12'hA5C, mode=00, one cs rise.
  - mosi sampled on each sclk falling edge reads 0000_1010_0101_1100.
  - Exactly 16 falling edges; sync_n low for 128 CLK cycles.
  - done pulses 4 cycles after sync_n rises; busy is high for the whole interval.
- Latch point: start a frame with sample=12'hFFF, then change it to 12'h000 one cycle after sync_n falls → transmitted bits are 0000_1111_1111_1111.
- Mode and boundary values: mode=11, sample=12'h000 → bits 0011_0000_0000_0000. Then mode=00, sample=12'hFFF → 0000_1111_1111_1111.
- Overrun: second cs rise 40 cycles into a frame → overrun=1 for one cycle; the first frame completes unchanged; no second frame starts until the next cs rise after done.
- Mid-frame reset: assert reset after the 7th sclk fall → sync_n=1 and sclk=1 in the same cycle. After release, a new cs rise yields a full, correct 16-bit frame.
- CLK_DIV=1: repeat the basic frame → sync_n low for 32 cycles; bit pattern identical.
